myproject_mul_share_sched: RTL and testbench
============================================

// Module: myproject_mul_share_sched
// PURPOSE
//  Time-multiplexes one 17ns x 18s -> 26-bit DSP multiplier among NUM_REQ requesters.
//  Grants at most one request per cycle, round-robin, with valid/ready handshakes.
//  Sits between the layer compute units and the shared mul_mul_17ns_18s_26 datapath.
//  Fixed 2-cycle pipeline; each result carries the winning requester's ID.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  ID_W      2    requester-ID width, = clog2(NUM_REQ)
//  A_W       17   operand A width, unsigned
//  B_W       18   operand B width, signed two's complement
//  P_W       26   product width, signed
// PORTS
//  ap_clk      in   1            clock, all state on rising edge
//  ap_rst_n    in   1            asynchronous active-low reset
//  req_valid   in   NUM_REQ      per-requester operand valid
//  req_ready   out  NUM_REQ      per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
//  req_b       in   NUM_REQ*B_W  packed operand B, requester i at [i*B_W +: B_W]
//  out_valid   out  1            product valid
//  out_ready   in   1            downstream accept
//  out_id      out  ID_W         requester that issued this product
//  out_p       out  P_W          product
// BEHAVIOUR
//  Reset (async assert, sync deassert internally): s1_valid=0, s2_valid=0,
//   out_valid=0, out_id=0, out_p=0, rr_ptr=0, req_ready=0.
//  Pipeline: S1 = registered operands + ID; S2 = registered product + ID (S2 drives out_*).
//  Stall = out_valid & ~out_ready. On stall, S1 and S2 hold and req_ready=0.
//  Advance: S2 loads from S1 when ~stall. S1 loads the granted request when ~stall;
//   if there is no grant, S1 loads s1_valid=0 (bubble).
//  Latency: accept in cycle N -> out_valid in cycle N+2 when there is no stall.
//   Throughput is 1 per cycle.
//  Transfer rules:
//   - A request transfers when req_valid[i] & req_ready[i] in the same cycle.
//   - Requesters hold a/b stable while valid & ~ready.
//   - req_ready is combinational from req_valid, rr_ptr and stall.
//  Arbitration: round-robin starting at rr_ptr.
//   - Grant = first i at or after rr_ptr (mod NUM_REQ) with req_valid[i].
//   - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ. Wrap from NUM_REQ-1 goes to 0.
//   - rr_ptr is unchanged when there is no grant or on stall.
//  Arithmetic: full = $signed({1'b0,a}) * $signed(b), 35 bits; out_p = full[P_W-1:0].
//   Truncation, no saturation; overflow wraps silently.
//  Simultaneous events:
//   - If out_ready rises in the same cycle as a stall condition clears, the grant
//     happens that cycle.
//   - Several requesters valid: exactly one ready bit is high.
//  Output ordering follows grant order; IDs are not reordered.
//  Reset mid-operation: in-flight S1/S2 contents are discarded and no output is produced
//   for them. Requesters must re-present their requests.
// STRUCTURE
//  Shared package (myproject_mul_pkg):
//   - A_W, B_W, P_W constants
//   - ID_W helper function clog2
//   - mul_req_t = {a, b}, mul_rsp_t = {id, p}
//  Sub-module myproject_rr_arb: req[NUM_REQ] + ptr -> onehot grant, grant_idx, any.
//   Purely combinational; rr_ptr register lives in the parent.
//  The multiplier instance is myproject_mul_mul_17ns_18s_26_1_1, placed between S1 and S2.
// TESTING
//  1. Single requester 0, a=3, b=-5 -> out_p=-15, out_id=0, out_valid exactly 2 cycles
//     after the handshake.
//  2. All 4 valid continuously, out_ready=1 -> grants 0,1,2,3,0,...; one result per cycle,
//     IDs in the same order.
//  3. rr_ptr=3, only req 1 and 3 valid -> grant 3, then 1 (wrap via 0).
//  4. out_ready=0 for 5 cycles with the pipe full -> req_ready=0, out_p/out_id held;
//     on release no loss and no duplication.
//  5. a=131071, b=-131072 -> out_p = low 26 bits of -17179738112 = 26'h0020000.
//  6. Assert ap_rst_n=0 with S1/S2 valid -> out_valid=0 immediately; after release,
//     the first new request is output correctly.

Source files
------------

// File: rtl/myproject_mul_pkg.sv
// Shared constants and types for the shared 17x18 multiplier scheduler.
package myproject_mul_pkg;

    localparam int A_W      = 17;
    localparam int B_W      = 18;
    localparam int P_W      = 26;
    localparam int ID_MAX_W = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } mul_req_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [P_W-1:0]      p;
    } mul_rsp_t;

endpackage

// File: rtl/myproject_mul_mul_17ns_18s_26_1_1.sv
// Combinational 17-bit unsigned x 18-bit signed multiply, truncated to 26 bits.
module myproject_mul_mul_17ns_18s_26_1_1
    import myproject_mul_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] b_ext;

    // The low P_W product bits depend only on the low P_W bits of the
    // extended operands, so a P_W-wide multiply gives the wrapped result.
    assign a_ext = P_W'(a);
    assign b_ext = {{(P_W-B_W){b[B_W-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/myproject_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module myproject_rr_arb
    import myproject_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/myproject_mul_share_sched.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters,
// with a 2-stage (operands, product) pipeline and backpressure.
module myproject_mul_share_sched
    import myproject_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [P_W-1:0]         out_p
);

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any;
    logic               stall;
    mul_req_t           nxt_op;
    logic               s1_valid;
    mul_req_t           s1_op;
    logic [ID_W-1:0]    s1_id;
    logic               s2_valid;
    logic [ID_W-1:0]    s2_id;
    logic [P_W-1:0]     s2_p;
    logic [P_W-1:0]     prod;

    // NOTE: reset asserts asynchronously but releases on a clock edge, so
    // every pipeline flop leaves reset in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    myproject_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign stall     = s2_valid & ~out_ready;
    assign req_ready = (rst_int_n & ~stall) ? grant : '0;

    always_comb begin
        nxt_op.a = req_a[grant_idx*A_W +: A_W];
        nxt_op.b = req_b[grant_idx*B_W +: B_W];
    end

    myproject_mul_mul_17ns_18s_26_1_1 u_mul (
        .a (s1_op.a),
        .b (s1_op.b),
        .p (prod)
    );

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous cycle's values of the others.
    always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_p     <= '0;
        end else if (!stall) begin
            s1_valid <= any;
            if (any) begin
                s1_op  <= nxt_op;
                s1_id  <= grant_idx;
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p  <= prod;
                s2_id <= s1_id;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_id    = s2_id;
    assign out_p     = s2_p;

endmodule

// File: tb/tb_myproject_mul_share_sched.sv
// Scoreboard bench for myproject_mul_share_sched: directed vectors with
// hand-computed products and grant orders, checked by an independent monitor.
module tb_myproject_mul_share_sched;
    import myproject_mul_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*A_W-1:0]   req_a;
    logic [N*B_W-1:0]   req_b;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [P_W-1:0]     out_p;

    always #5 ap_clk = ~ap_clk;

    myproject_mul_share_sched #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_p     (out_p)
    );

    typedef struct {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [P_W-1:0] p;
    } op_t;

    typedef struct {
        int             id;
        logic [P_W-1:0] p;
        int             due;
    } exp_t;

    op_t  pend[N][$];
    exp_t sb[$];
    int   exp_grants[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;
    int   stall_from = -1;
    int   stall_len  = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input longint a, input longint b, input longint p);
        op_t o;
        o.a = A_W'(a);
        o.b = B_W'(b);
        o.p = P_W'(p);
        return o;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (pend[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Presents each requester's queued operands, records handshakes into the
    // scoreboard, and optionally waits for every expected result to drain.
    task automatic run(input int budget, input bit drain);
        int n;
        int w;
        exp_t e;
        n = 0;
        while (n < budget && pending()) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (pend[i].size() > 0);
                if (pend[i].size() > 0) begin
                    req_a[i*A_W +: A_W] = pend[i][0].a;
                    req_b[i*B_W +: B_W] = pend[i][0].b;
                end
            end
            out_ready = !(n >= stall_from && n < stall_from + stall_len);
            @(negedge ap_clk);
            check("ready_subset", 64'(req_ready & ~req_valid), 0);
            if (out_valid && !out_ready)
                check("ready_in_stall", 64'(req_ready), 0);
            else if (req_valid != '0)
                check("onehot_ready", 64'($countones(req_ready)), 1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (exp_grants.size() == 0) check("grant_extra", 64'(i), 99);
                    else                        check("grant_order", 64'(i), 64'(exp_grants.pop_front()));
                    e.id  = i;
                    e.p   = pend[i][0].p;
                    e.due = lat_chk ? cyc + 2 : -1;
                    sb.push_back(e);
                    void'(pend[i].pop_front());
                end
            end
            @(posedge ap_clk);
            #1;
            n++;
        end
        req_valid = '0;
        out_ready = 1'b1;
        if (drain) begin
            check("stim_timeout", 64'(pending()), 0);
            w = 0;
            while (sb.size() > 0 && w < 20) begin
                @(posedge ap_clk);
                #1;
                w++;
            end
            check("drain", 64'(sb.size()), 0);
            check("grants_consumed", 64'(exp_grants.size()), 0);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb[0];
                    check("out_id", 64'(out_id), 64'(e.id));
                    check("out_p", 64'(out_p), 64'(e.p));
                    if (out_ready) begin
                        if (e.due >= 0) check("latency", 64'(cyc), 64'(e.due));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        ap_rst_n  = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("reset_ready", 64'(req_ready), 0);
        check("reset_valid", 64'(out_valid), 0);
        check("reset_id", 64'(out_id), 0);
        check("reset_p", 64'(out_p), 0);
        req_valid = '0;
        ap_rst_n  = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;

        // Single request, 2-cycle latency
        lat_chk = 1'b1;
        pend[0].push_back(mk(3, -5, -15));
        exp_grants = '{0};
        run(10, 1);

        // All four valid, round-robin from ptr=1
        pend[0].push_back(mk(10, 20, 200));
        pend[0].push_back(mk(7, -3, -21));
        pend[1].push_back(mk(100, -100, -10000));
        pend[1].push_back(mk(0, 5, 0));
        pend[2].push_back(mk(65535, 2, 131070));
        pend[2].push_back(mk(1, -131072, -131072));
        pend[3].push_back(mk(12345, -1, -12345));
        pend[3].push_back(mk(2, 2, 4));
        exp_grants = '{1, 2, 3, 0, 1, 2, 3, 0};
        run(30, 1);

        // Move ptr to 3, then requesters 1 and 3 together: 3 wins, then 1
        pend[2].push_back(mk(2, -2, -4));
        exp_grants = '{2};
        run(10, 1);
        pend[1].push_back(mk(17, -19, -323));
        pend[3].push_back(mk(11, 13, 143));
        exp_grants = '{3, 1};
        run(10, 1);

        // Backpressure for 5 cycles with the pipe full
        lat_chk    = 1'b0;
        stall_from = 3;
        stall_len  = 5;
        pend[0].push_back(mk(3, 3, 9));
        pend[0].push_back(mk(4, 4, 16));
        pend[1].push_back(mk(5, 5, 25));
        pend[1].push_back(mk(6, -6, -36));
        pend[2].push_back(mk(7, 7, 49));
        pend[2].push_back(mk(8, -8, -64));
        pend[3].push_back(mk(9, 9, 81));
        pend[3].push_back(mk(10, -10, -100));
        exp_grants = '{2, 3, 0, 1, 2, 3, 0, 1};
        run(40, 1);
        stall_from = -1;
        stall_len  = 0;

        // Extreme operands, truncation wraps
        lat_chk = 1'b1;
        pend[0].push_back(mk(131071, -131072, 64'sh0020000));
        pend[1].push_back(mk(131071, 131071, 64'sh3FC0001));
        exp_grants = '{0, 1};
        run(10, 1);

        // Reset with S1/S2 occupied
        lat_chk = 1'b0;
        for (int i = 0; i < N; i++) pend[i].push_back(mk(i + 1, i + 1, (i + 1) * (i + 1)));
        exp_grants = '{2, 3, 0};
        run(3, 0);
        check("pre_reset_valid", 64'(out_valid), 1);
        ap_rst_n = 1'b0;
        #1;
        check("mid_reset_valid", 64'(out_valid), 0);
        check("mid_reset_id", 64'(out_id), 0);
        check("mid_reset_p", 64'(out_p), 0);
        sb.delete();
        exp_grants.delete();
        for (int i = 0; i < N; i++) pend[i].delete();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        lat_chk = 1'b1;
        pend[3].push_back(mk(1000, -7, -7000));
        exp_grants = '{3};
        run(10, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
